// File: rtl/ext_dev_source.sv
// External I/O device model upstream of the DMA engine: buffers a word-wide payload,
// signals readiness after a fixed latency and serves 64-bit blocks during the granted transfer.
module ext_dev_source #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned NUM_BLOCKS = 3,
    parameter int unsigned DEV_DELAY  = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic                   BG,
    input  logic [1:0]             offset,
    output logic [4*WORD_SIZE-1:0] edata,
    output logic                   dev_int,
    output logic                   busy,
    output logic [3:0]             fill_cnt,
    output logic                   err
);

    localparam int unsigned NumWords  = 4 * NUM_BLOCKS;
    localparam int unsigned DelayW    = $clog2(DEV_DELAY) + 1;
    localparam logic [3:0]  LastIdx   = 4'(NumWords - 1);
    localparam logic [DelayW-1:0] DelayLoad = DelayW'(DEV_DELAY - 1);

    typedef enum logic [2:0] {StEmpty, StFill, StWait, StReady, StXfer} state_e;

    state_e                state_q, state_d;
    logic [3:0]            fill_cnt_q, fill_cnt_d;
    logic [DelayW-1:0]     delay_q, delay_d;
    logic                  dev_int_q, dev_int_d;
    logic                  err_q, err_d;
    logic [WORD_SIZE-1:0]  buf_q [NumWords];
    logic [WORD_SIZE-1:0]  buf_d [NumWords];
    logic                  offset_ok;
    logic [3:0]            word_idx;

    assign offset_ok = ({30'd0, offset} < NUM_BLOCKS);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        delay_d    = delay_q;
        dev_int_d  = dev_int_q;
        err_d      = err_q;
        buf_d      = buf_q;
        unique case (state_q)
            StEmpty: begin
                if (wr_en) begin
                    buf_d[0]   = wr_data;
                    fill_cnt_d = 4'd1;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (wr_en) begin
                    buf_d[fill_cnt_q] = wr_data;
                    fill_cnt_d        = fill_cnt_q + 4'd1;
                    if (fill_cnt_q == LastIdx) begin
                        delay_d = DelayLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wr_en) err_d = 1'b1;
                if (delay_q == '0) begin
                    state_d   = StReady;
                    dev_int_d = 1'b1;
                end else begin
                    delay_d = delay_q - DelayW'(1);
                end
            end
            StReady: begin
                if (wr_en) err_d = 1'b1;
                if (BG) begin
                    state_d   = StXfer;
                    dev_int_d = 1'b0;
                end
            end
            StXfer: begin
                if (wr_en || !offset_ok) err_d = 1'b1;
                // Grant release consumes the payload; a re-grant is only seen from EMPTY onward.
                if (!BG) begin
                    state_d    = StEmpty;
                    fill_cnt_d = 4'd0;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StEmpty;
            fill_cnt_q <= 4'd0;
            delay_q    <= '0;
            dev_int_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            delay_q    <= delay_d;
            dev_int_q  <= dev_int_d;
            err_q      <= err_d;
        end
    end

    // Payload storage needs no reset; it is only read once a full fill has overwritten it.
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
    end

    // Zero-latency block select so the DMA sees a new offset in the same cycle.
    always_comb begin
        edata    = '0;
        word_idx = '0;
        if ((state_q == StReady || state_q == StXfer) && offset_ok) begin
            for (int k = 0; k < 4; k++) begin
                word_idx = {offset, 2'(k)};
                edata[k*WORD_SIZE +: WORD_SIZE] = buf_q[word_idx];
            end
        end
    end

    assign busy     = (state_q != StEmpty);
    assign dev_int  = dev_int_q;
    assign fill_cnt = fill_cnt_q;
    assign err      = err_q;

endmodule
